// File: rtl/mutex_rr_scheduler_if.sv
// Request/grant bundle between requesters and the mutex round-robin scheduler.
// Requesters sit on the master side; the scheduler is the slave.
interface mutex_rr_scheduler_if #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );
endinterface

// File: rtl/mutex_rr_scheduler.sv
// Round-robin owner of one mutually exclusive resource among N requesters.
// One-hot registered grant, bounded hold with preemption, dead gap between owners.
module mutex_rr_scheduler #(
  parameter int N          = 4,
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mutex_rr_scheduler_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam int GW = 4;
  localparam logic [HW-1:0] HLIM =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [GW-1:0] GLIM =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t        state;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          busy;
  logic          timeout;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] gap_cnt;

  logic [IW-1:0] win;
  logic [IW-1:0] nxt_ptr;
  logic          own_req;
  logic          preempt;

  // first set bit at or after p, wrapping mod N
  function automatic logic [IW-1:0] pick(
    input logic [N-1:0]  r,
    input logic [IW-1:0] p
  );
    logic [IW-1:0] w;
    logic          hit;
    int            idx;
    w   = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(p) + i;
      if (idx >= N) idx = idx - N;
      if (!hit && r[idx]) begin
        hit = 1'b1;
        w   = IW'(idx);
      end
    end
    return w;
  endfunction

  always_comb begin
    win     = pick(bus.req, ptr);
    own_req = bus.req[grant_id];
    preempt = (MAX_HOLD != 0) && (hold_cnt == HLIM);
    nxt_ptr = (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            grant    <= N'(1) << win;
            grant_id <= win;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!own_req || preempt) begin
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            ptr      <= nxt_ptr;
            // a voluntary drop wins over preemption: no pulse then
            timeout  <= own_req;
            gap_cnt  <= '0;
            state    <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GLIM) state <= IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant;
  assign bus.grant_id = grant_id;
  assign bus.busy     = busy;
  assign bus.timeout  = timeout;
endmodule

// File: tb/tb_mutex_rr_scheduler.sv
// Directed bench for mutex_rr_scheduler: N=4, GAP=1, MAX_HOLD=8 and MAX_HOLD=0.
// Observed vector is {grant, grant_id, busy, timeout}.
module tb_mutex_rr_scheduler;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mutex_rr_scheduler_if #(.N(4)) a ();
  mutex_rr_scheduler_if #(.N(4)) b ();

  mutex_rr_scheduler #(
    .N(4), .MAX_HOLD(8), .GAP_CYCLES(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a.slave)
  );

  mutex_rr_scheduler #(
    .N(4), .MAX_HOLD(0), .GAP_CYCLES(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs_a();
    return {a.grant, a.grant_id, a.busy, a.timeout};
  endfunction

  function automatic logic [7:0] obs_b();
    return {b.grant, b.grant_id, b.busy, b.timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a.req = '0;
    b.req = '0;
    step();
    step();
    checks++;
    if (obs_a() !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: got %b want %b", obs_a(), 8'h00);
    end
    checks++;
    if (obs_b() !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: got %b want %b", obs_b(), 8'h00);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] exp;
    a.req = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      step();
      exp = (c <= 5) ? 8'b0100_10_1_0 : 8'h00;
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL single c%0d: got %b want %b", c, obs_a(), exp);
      end
      if (c == 5) a.req = 4'b0000;
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp;
    int p;
    int k;
    a.req = 4'b1111;
    for (int c = 1; c <= 50; c++) begin
      step();
      p = (c - 1) % 10;
      k = ((c - 1) / 10) % 4;
      if (p < 8) exp = {4'(1 << k), 2'(k), 1'b1, 1'b0};
      else       exp = {4'b0, 2'b0, 1'b0, (p == 8)};
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL rotation c%0d: got %b want %b", c, obs_a(), exp);
      end
    end
    a.req = '0;
  endtask

  task automatic test_skip();
    logic [7:0] exp;
    a.req = 4'b0010;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c <= 4)      exp = 8'b0010_01_1_0;
      else if (c == 7) exp = 8'b1000_11_1_0;
      else             exp = 8'h00;
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL skip c%0d: got %b want %b", c, obs_a(), exp);
      end
      if (c == 1) a.req = 4'b1011;
      if (c == 4) a.req = 4'b1001;
    end
    a.req = '0;
  endtask

  task automatic test_drop_at_limit();
    logic [7:0] exp;
    a.req = 4'b0001;
    for (int c = 1; c <= 11; c++) begin
      step();
      exp = (c <= 8) ? 8'b0001_00_1_0 : 8'h00;
      checks++;
      if (obs_a() !== exp) begin
        errors++;
        $display("FAIL droplim c%0d: got %b want %b", c, obs_a(), exp);
      end
      if (c == 8) a.req = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    a.req = 4'b0100;
    step();
    a.req = 4'b0000;
    step();
    a.req = 4'b0010;
    step();
    step();
    checks++;
    if (obs_a() !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL arst_pre: got %b want %b", obs_a(), 8'b0010_01_1_0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a() !== 8'h00) begin
      errors++;
      $display("FAIL arst_drop: got %b want %b", obs_a(), 8'h00);
    end
    a.req = 4'b1010;
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (obs_a() !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL arst_ptr: got %b want %b", obs_a(), 8'b0010_01_1_0);
    end
    a.req = '0;
  endtask

  task automatic test_no_limit();
    b.req = 4'b0001;
    for (int c = 1; c <= 100; c++) begin
      step();
      checks++;
      if (obs_b() !== 8'b0001_00_1_0) begin
        errors++;
        $display("FAIL nolimit c%0d: got %b want %b", c, obs_b(), 8'b0001_00_1_0);
      end
    end
    b.req = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_reset();
    test_rotation();
    test_reset();
    test_skip();
    test_reset();
    test_drop_at_limit();
    test_reset();
    test_async_reset();
    test_reset();
    test_no_limit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
